// File: rtl/booth_acc_shift.sv
// Sequential radix-2 Booth multiplier: one add/subtract plus arithmetic right shift per clock,
// W+1-bit accumulator so the most negative multiplicand is handled exactly.
module booth_acc_shift #(
  parameter int W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [W-1:0]     Multiplicand,
  input  logic [W-1:0]     Multiplier,
  output logic             Busy,
  output logic             Done,
  output logic [2*W-1:0]   Product
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] COUNT_LOAD = CW'(W);
  localparam logic [CW-1:0] COUNT_LAST = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  state_t                state_nxt;
  logic signed [W:0]     acc;
  logic signed [W:0]     mcand;
  logic [W-1:0]          q_reg;
  logic                  q_1;
  logic [CW-1:0]         count;
  logic signed [W:0]     sum;
  logic signed [W:0]     acc_shift;
  logic [W-1:0]          q_shift;
  logic                  last;

  // Booth recoding of the pair {Q[0], Q_-1}; W+1-bit arithmetic never wraps for W-bit operands.
  function automatic logic signed [W:0] booth_add(
    input logic signed [W:0] a,
    input logic signed [W:0] m,
    input logic [1:0]        pair
  );
    case (pair)
      2'b01:   return a + m;
      2'b10:   return a - m;
      default: return a;
    endcase
  endfunction

  always_comb begin
    sum       = booth_add(acc, mcand, {q_reg[0], q_1});
    acc_shift = {sum[W], sum[W:1]};
    q_shift   = {sum[0], q_reg[W-1:1]};
    last      = (count == COUNT_LAST);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
    endcase
  end

  // Multiplicand is pure data captured at load; it needs no reset.
  always_ff @(posedge Clk) begin
    if (state == IDLE && Start) begin
      mcand <= {Multiplicand[W-1], Multiplicand};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Product <= '0;
      acc     <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
    end else begin
      Done <= 1'b0;
      if (state == IDLE) begin
        if (Start) begin
          acc   <= '0;
          q_reg <= Multiplier;
          q_1   <= 1'b0;
          count <= COUNT_LOAD;
          Busy  <= 1'b1;
        end
      end else begin
        acc   <= acc_shift;
        q_reg <= q_shift;
        q_1   <= q_reg[0];
        count <= count - COUNT_LAST;
        // The final iteration publishes the post-shift {A, Q} directly.
        if (last) begin
          Product <= {acc_shift[W-1:0], q_shift};
          Done    <= 1'b1;
          Busy    <= 1'b0;
        end
      end
    end
  end

endmodule
